// File: rtl/shift_add_mul_sched.sv
// Round-robin scheduler that shares one shift-add multiplier among NREQ clients.
// Grants one requester, issues its operands, waits for done/timeout and returns the product.
module shift_add_mul_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 31,
  parameter int TIMEOUT = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      res_valid,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product
);

  // state | meaning
  // IDLE  | no op in flight; arbitrate req from ptr
  // ISSUE | operands latched, mul_start high this cycle
  // WAIT  | waiting for mul_done or timeout
  // RESP  | res_valid pulse to granted client, advance ptr

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   k_q;
  logic [PW-1:0]   k_sel;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NREQ);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int j = 0; j < NREQ; j++)
      if (idx == PW'(j)) oh[j] = 1'b1;
    return oh;
  endfunction

  // Circular search for the first request at or after ptr
  always_comb begin
    found = 1'b0;
    k_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[wrap(int'(ptr) + i)]) begin
        found = 1'b1;
        k_sel = wrap(int'(ptr) + i);
      end
    end
  end

  assign timeout_hit = (cnt == CW'(TIMEOUT-1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (found) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (mul_done || timeout_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr              <= '0;
      k_q              <= '0;
      cnt              <= '0;
      gnt              <= '0;
      mul_start        <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      res_valid        <= '0;
      res_data         <= '0;
      res_err          <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      res_valid <= '0;
      res_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            k_q              <= k_sel;
            gnt              <= onehot(k_sel);
            mul_multiplier   <= a_in[int'(k_sel)*WIDTH +: WIDTH];
            mul_multiplicand <= b_in[int'(k_sel)*WIDTH +: WIDTH];
            mul_start        <= 1'b1;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (mul_done) begin
            res_valid <= onehot(k_q);
            res_data  <= mul_product;
          end else if (timeout_hit) begin
            res_valid <= onehot(k_q);
            res_data  <= '0;
            res_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          ptr <= wrap(int'(k_q) + 1);
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
